uart_tx_8n1: RTL and testbench

//   UART transmitter for the serial link, 8N1 framing (1 start, 8 data LSB-first,
//   1 stop, no parity). Pairs with the receive path: same clock, same bit period.

---
 rtl/uart_tx_8n1_if.sv | 31 +++
 rtl/uart_tx_8n1.sv | 132 +++++++++++++
 tb/tb_uart_tx_8n1.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_8n1_if.sv
// ---------------------------------------------------------------------------
// uart_tx_8n1_if : byte handshake and serial line bundle for uart_tx_8n1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_tx_8n1_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  txd,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output txd,
    output tx_busy,
    output tx_done
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_8n1.sv
// ---------------------------------------------------------------------------
// uart_tx_8n1 : 8N1 UART transmitter, LSB first, all outputs registered
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 1302,
  parameter int DATA_BITS    = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  uart_tx_8n1_if.slave  tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0]   r_shreg, w_shreg_nxt;
  logic                   r_txd, w_txd_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;

  logic                   w_bit_end;
  logic [IDX_W-1:0]       w_idx_inc;

  assign w_bit_end = (r_cnt == C_CNT_LAST);
  assign w_idx_inc = r_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state values are what the line carries after the edge, so txd,
  // tx_busy and tx_done come straight from flops with no input-to-output path.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_txd_nxt   = r_txd;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt  = '0;
        w_idx_nxt  = '0;
        w_txd_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
        if (tx.tx_start) begin
          w_shreg_nxt = tx.tx_data;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = '0;
          w_txd_nxt   = r_shreg[0];
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == C_IDX_LAST) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_idx_nxt = w_idx_inc;
            w_txd_nxt = r_shreg[w_idx_inc];
          end
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_txd_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_txd_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign tx.txd     = r_txd;
  assign tx.tx_busy = r_busy;
  assign tx.tx_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_8n1.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_8n1 : frame-table checks plus mid-bit receiver scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_8n1;

  localparam int CPB    = 16;
  localparam int CPB_LB = 1302;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // frame[0] is the start bit, frame[9] the stop bit
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];
  bit   sel_lb  = 1'b0;
  int   mon_cpb = CPB;
  vec_t vecs[5];

  uart_tx_8n1_if bus();
  uart_tx_8n1_if bus_lb();

  uart_tx_8n1 #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (rst),
    .tx    (bus)
  );

  uart_tx_8n1 #(.CLKS_PER_BIT(CPB_LB), .DATA_BITS(8)) dut_lb (
    .clk   (clk),
    .reset (rst),
    .tx    (bus_lb)
  );

  always #5 clk = ~clk;

  wire logic mon_txd = sel_lb ? bus_lb.txd : bus.txd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_done(input bit lb, input int bound, output int n);
    n = 0;
    while (((lb ? bus_lb.tx_done : bus.tx_done) !== 1'b1) && (n < bound)) begin
      tick();
      n++;
    end
  endtask

  // Drive one frame and check every cycle of it against the table entry.
  task automatic run_vec(input vec_t v);
    logic [2:0] bad;
    logic [2:0] req;
    bit         ok;
    bus.tx_data  = v.data;
    bus.tx_start = 1'b1;
    exp_q.push_back(v.data);
    tick();
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'($urandom);
    for (int j = 0; j < 10; j++) begin
      ok  = 1'b1;
      req = {2'b10, v.frame[j]};
      bad = req;
      for (int c = 0; c < CPB; c++) begin
        if (ok && ({bus.tx_busy, bus.tx_done, bus.txd} !== req)) begin
          ok  = 1'b0;
          bad = {bus.tx_busy, bus.tx_done, bus.txd};
        end
        tick();
      end
      chk($sformatf("frame_%02h_bit%0d_{busy,done,txd}", v.data, j), {29'd0, bad}, {29'd0, req});
    end
    chk($sformatf("frame_%02h_done_{busy,done,txd}", v.data),
        {29'd0, bus.tx_busy, bus.tx_done, bus.txd}, 32'd3);
    tick();
    chk($sformatf("frame_%02h_done_oneshot", v.data), {31'd0, bus.tx_done}, 32'd0);
  endtask

  // Receiver model: samples each bit at its middle and scores against exp_q.
  initial begin : monitor
    logic [7:0] got;
    logic       stop_bit;
    logic [7:0] expd;
    bit         ok;
    int         wait_n;
    forever begin
      tick();
      if (!rst && mon_txd === 1'b0) begin
        ok       = 1'b1;
        got      = 8'h00;
        stop_bit = 1'b0;
        for (int n = 0; n < 10 && ok; n++) begin
          wait_n = (n == 0) ? mon_cpb / 2 : mon_cpb;
          for (int c = 0; c < wait_n; c++) begin
            tick();
            if (rst) ok = 1'b0;
          end
          if (ok && n >= 1 && n <= 8) got[n-1] = mon_txd;
          if (ok && n == 9) stop_bit = mon_txd;
        end
        if (ok) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected_frame actual=%02h required=none", got);
          end else begin
            expd = exp_q.pop_front();
            if (got !== expd || stop_bit !== 1'b1) begin
              errors++;
              $display("FAIL rx_byte actual=%02h stop=%b required=%02h stop=1", got, stop_bit, expd);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : main
    int n;
    int extra;

    vecs[0] = '{8'hA3, 10'b1_1010_0011_0};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
    vecs[3] = '{8'h5A, 10'b1_0101_1010_0};
    vecs[4] = '{8'h81, 10'b1_1000_0001_0};

    bus.tx_start    = 1'b0;
    bus.tx_data     = 8'h00;
    bus_lb.tx_start = 1'b0;
    bus_lb.tx_data  = 8'h00;

    // Reset values from the first edge with reset high
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset_cycle%0d_{busy,done,txd}", i),
          {29'd0, bus.tx_busy, bus.tx_done, bus.txd}, 32'd1);
    end
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Start request while busy is ignored
    bus.tx_data  = 8'h55;
    bus.tx_start = 1'b1;
    exp_q.push_back(8'h55);
    tick();
    bus.tx_start = 1'b0;
    repeat (CPB * 4 + CPB / 2) tick();
    bus.tx_data  = 8'hFF;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    wait_done(1'b0, 200, n);
    chk("busy_start_done_latency", n, 10 * CPB - (CPB * 4 + CPB / 2 + 1));
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.txd !== 1'b1 || bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0) extra++;
    end
    chk("busy_start_no_second_frame", extra, 0);

    // Back-to-back frames with tx_start held high
    bus.tx_data  = 8'h0F;
    bus.tx_start = 1'b1;
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hF0);
    tick();
    repeat (20) tick();
    bus.tx_data = 8'hF0;
    wait_done(1'b0, 200, n);
    chk("b2b_first_done_latency", n, 10 * CPB - 20);
    chk("b2b_done_line_high", {31'd0, bus.txd}, 32'd1);
    tick();
    chk("b2b_second_start_{busy,done,txd}", {29'd0, bus.tx_busy, bus.tx_done, bus.txd}, 32'd4);
    bus.tx_start = 1'b0;
    wait_done(1'b0, 200, n);
    chk("b2b_second_done_latency", n, 10 * CPB);
    tick();

    // Reset during bit 4 abandons the frame
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    repeat (CPB * 5 + CPB / 2) tick();
    chk("pre_reset_txd_low", {31'd0, bus.txd}, 32'd0);
    rst = 1'b1;
    tick();
    chk("midframe_reset_{busy,done,txd}", {29'd0, bus.tx_busy, bus.tx_done, bus.txd}, 32'd1);
    tick();
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.tx_done !== 1'b0 || bus.txd !== 1'b1) extra++;
    end
    chk("midframe_reset_no_done", extra, 0);
    run_vec('{8'h3C, 10'b1_0011_1100_0});

    // Loopback at the production bit period
    sel_lb  = 1'b1;
    mon_cpb = CPB_LB;
    for (int i = 0; i < 3; i++) begin
      bus_lb.tx_data  = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h5A;
      bus_lb.tx_start = 1'b1;
      exp_q.push_back(bus_lb.tx_data);
      tick();
      bus_lb.tx_start = 1'b0;
      wait_done(1'b1, 10 * CPB_LB + 20, n);
      chk($sformatf("loopback%0d_done_latency", i), n, 10 * CPB_LB);
      tick();
    end
    repeat (10) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
